e_mdu: RTL and testbench

- Execute-stage multiply/divide unit.
- Sits beside the ALU and consumes the forwarded operands E_V1_f / E_V2_f produced by the E-stage forwarding muxes.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Exports busy/start so the hazard unit can stall md-type instructions in D.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/e_mdu.sv | 159 +++++++++++++++
 tb/tb_e_mdu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, controller states and default latencies.
// Imported by the E-stage MDU controller and by the hazard unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers plus a busy counter modelling latency.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu; otherwise those encodings are no-ops.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1_f,
    input  logic [31:0] E_V2_f,
    input  logic [3:0]  MDUOp_E,
    input  logic        MDUStart_E,
    input  logic        MDUWe_E,
    output logic [31:0] E_MDU_out,
    output logic        MDUBusy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    mdu_op_e    op;
    mdu_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] tmp_q, tmp_d;
    logic        commit_q, commit_d;

    assign op = mdu_op_e'(MDUOp_E);

    // Products: low 64 bits of a 64x64 multiply of the extended operands.
    logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    assign a_sx   = {{32{E_V1_f[31]}}, E_V1_f};
    assign b_sx   = {{32{E_V2_f[31]}}, E_V2_f};
    assign a_zx   = {32'd0, E_V1_f};
    assign b_zx   = {32'd0, E_V2_f};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // 33-bit signed division makes 0x80000000 / -1 yield quotient 0x80000000, remainder 0.
    logic        div_zero;
    logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
    logic [31:0] dvs_u, quo_u, rem_u;
    logic        unused_div_msbs;

    assign div_zero        = (E_V2_f == 32'd0);
    assign dvd_s           = {E_V1_f[31], E_V1_f};
    assign dvs_s           = div_zero ? 33'sd1 : {E_V2_f[31], E_V2_f};
    assign quo_s           = dvd_s / dvs_s;
    assign rem_s           = dvd_s % dvs_s;
    assign dvs_u           = div_zero ? 32'd1 : E_V2_f;
    assign quo_u           = E_V1_f / dvs_u;
    assign rem_u           = E_V1_f % dvs_u;
    assign unused_div_msbs = quo_s[32] ^ rem_s[32];

    // Operation decode: whether a start launches, its result, latency and whether it commits.
    logic          md_go, md_wr;
    logic [63:0]   md_res;
    logic [CW-1:0] md_lat;

    always_comb begin
        md_go  = 1'b0;
        md_wr  = 1'b1;
        md_res = prod_u;
        md_lat = CW'(MULT_CYCLES);
        case (op)
            MDU_MULT:  begin md_go = 1'b1; md_res = prod_s; end
            MDU_MULTU: begin md_go = 1'b1; md_res = prod_u; end
            MDU_DIV: begin
                md_go  = 1'b1;
                md_res = {rem_s[31:0], quo_s[31:0]};
                md_lat = CW'(DIV_CYCLES);
                md_wr  = !div_zero;
            end
            MDU_DIVU: begin
                md_go  = 1'b1;
                md_res = {rem_u, quo_u};
                md_lat = CW'(DIV_CYCLES);
                md_wr  = !div_zero;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  begin md_go = 1'b1; md_res = {hi_q, lo_q} + prod_s; end
            MDU_MADDU: begin md_go = 1'b1; md_res = {hi_q, lo_q} + prod_u; end
            MDU_MSUB:  begin md_go = 1'b1; md_res = {hi_q, lo_q} - prod_s; end
            MDU_MSUBU: begin md_go = 1'b1; md_res = {hi_q, lo_q} - prod_u; end
`else
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: md_go = 1'b0;
`endif
            default: md_go = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_d    = tmp_q;
        commit_d = commit_q;
        case (state_q)
            MDU_IDLE: begin
                // Start takes priority over a simultaneous move-to.
                if (MDUStart_E) begin
                    if (md_go) begin
                        state_d  = MDU_BUSY;
                        cnt_d    = md_lat;
                        tmp_d    = md_res;
                        commit_d = md_wr;
                    end
                end else if (MDUWe_E) begin
                    if (op == MDU_MTHI) hi_d = E_V1_f;
                    if (op == MDU_MTLO) lo_d = E_V1_f;
                end
            end
            MDU_BUSY: begin
                if (cnt_q <= CW'(1)) begin
                    state_d  = MDU_IDLE;
                    cnt_d    = '0;
                    commit_d = 1'b0;
                    if (commit_q) begin
                        hi_d = tmp_q[63:32];
                        lo_d = tmp_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_q    <= tmp_d;
            commit_q <= commit_d;
        end
    end

    assign MDUBusy   = (state_q == MDU_BUSY);
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;
    assign E_MDU_out = (op == MDU_MFHI) ? hi_q :
                       (op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios followed by randomized operations
// compared against an arithmetic reference model of HI/LO and busy latency.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_V1_f, E_V2_f;
    logic [3:0]  MDUOp_E;
    logic        MDUStart_E, MDUWe_E;
    logic [31:0] E_MDU_out, HI_out, LO_out;
    logic        MDUBusy;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_V1_f    (E_V1_f),
        .E_V2_f    (E_V2_f),
        .MDUOp_E   (MDUOp_E),
        .MDUStart_E(MDUStart_E),
        .MDUWe_E   (MDUWe_E),
        .E_MDU_out (E_MDU_out),
        .MDUBusy   (MDUBusy),
        .HI_out    (HI_out),
        .LO_out    (LO_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The pipeline never issues start or move-to while the unit is busy.
    always @(negedge clk) begin
        if (!reset && MDUBusy) begin
            checks++;
            assert (!(MDUStart_E || MDUWe_E)) else begin
                errors++;
                $error("FAIL no_issue_while_busy: observed start=%b we=%b expected 0", MDUStart_E, MDUWe_E);
            end
        end
    end

    // Reference model: {HI,LO} after the operation and its busy latency.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, inout logic [31:0] hi, inout logic [31:0] lo);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        acc = {hi, lo};
        lat = 0;
        case (op)
            MDU_MULT:  begin lat = MC; {hi, lo} = 64'(sa * sb); end
            MDU_MULTU: begin lat = MC; {hi, lo} = 64'(ua * ub); end
            MDU_DIV: begin
                lat = DC;
                if (b != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            MDU_DIVU: begin
                lat = DC;
                if (b != 0) begin lo = a / b; hi = a % b; end
            end
            MDU_MTHI: hi = a;
            MDU_MTLO: lo = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin lat = MC; {hi, lo} = acc + 64'(sa * sb); end
            MDU_MADDU: begin lat = MC; {hi, lo} = acc + 64'(ua * ub); end
            MDU_MSUB:  begin lat = MC; {hi, lo} = acc - 64'(sa * sb); end
            MDU_MSUBU: begin lat = MC; {hi, lo} = acc - 64'(ua * ub); end
`endif
            default: lat = 0;
        endcase
    endtask

    // Issue one operation from the drive phase; reads HI via mfhi throughout the busy window.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo, old_hi;
        int          lat, cnt;
        logic        is_we;
        ehi    = m_hi;
        elo    = m_lo;
        old_hi = m_hi;
        is_we  = (op == MDU_MTHI) || (op == MDU_MTLO);
        model(op, a, b, lat, ehi, elo);
        E_V1_f     = a;
        E_V2_f     = b;
        MDUOp_E    = op;
        MDUStart_E = !is_we;
        MDUWe_E    = is_we;
        @(posedge clk); #1;
        MDUStart_E = 1'b0;
        MDUWe_E    = 1'b0;
        MDUOp_E    = MDU_MFHI;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!MDUBusy) break;
            cnt++;
            chk("mfhi_old_during_busy", E_MDU_out, old_hi);
        end
        chk("busy_cycles", 32'(cnt), 32'(lat));
        chk("hi", HI_out, ehi);
        chk("lo", LO_out, elo);
        chk("mfhi_after", E_MDU_out, ehi);
        MDUOp_E = MDU_MFLO;
        #1;
        chk("mflo_after", E_MDU_out, elo);
        m_hi = ehi;
        m_lo = elo;
        @(posedge clk); #1;
        MDUOp_E = MDU_NOP;
    endtask

    logic [3:0]  ops [10] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI,
                              MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    logic [31:0] specials [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h7FFF_FFFF};

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        reset      = 1'b1;
        E_V1_f     = '0;
        E_V2_f     = '0;
        MDUOp_E    = MDU_NOP;
        MDUStart_E = 1'b0;
        MDUWe_E    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, MDUBusy}, 32'd0);
        chk("reset_hi", HI_out, 32'd0);
        chk("reset_lo", LO_out, 32'd0);
        chk("reset_out", E_MDU_out, 32'd0);
        @(posedge clk); #1;

        run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        chk("tp_mult_hi", HI_out, 32'hFFFF_FFFF);
        chk("tp_mult_lo", LO_out, 32'hFFFF_FFFE);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("tp_multu_hi", HI_out, 32'h0000_0001);
        chk("tp_multu_lo", LO_out, 32'hFFFF_FFFE);
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("tp_div_lo", LO_out, 32'hFFFF_FFFD);
        chk("tp_div_hi", HI_out, 32'hFFFF_FFFF);
        run_op(MDU_DIVU, 32'd7, 32'd2);
        chk("tp_divu_lo", LO_out, 32'd3);
        chk("tp_divu_hi", HI_out, 32'd1);
        run_op(MDU_MTLO, 32'h1234_5678, 32'd0);
        run_op(MDU_DIVU, 32'd5, 32'd0);
        chk("tp_div0_lo", LO_out, 32'h1234_5678);
        chk("tp_div0_hi", HI_out, 32'd1);
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("tp_ovf_lo", LO_out, 32'h8000_0000);
        chk("tp_ovf_hi", HI_out, 32'd0);

        run_op(MDU_MTHI, 32'd0, 32'd0);
        run_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        run_op(MDU_MADD, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("tp_madd_hi", HI_out, 32'd1);
        chk("tp_madd_lo", LO_out, 32'd0);
`else
        chk("tp_madd_hi", HI_out, 32'd0);
        chk("tp_madd_lo", LO_out, 32'hFFFF_FFFF);
`endif

        // Reset in the third busy cycle of a divide discards its result.
        run_op(MDU_MTHI, 32'hAAAA_5555, 32'd0);
        E_V1_f = 32'd100; E_V2_f = 32'd7; MDUOp_E = MDU_DIVU; MDUStart_E = 1'b1;
        @(posedge clk); #1 MDUStart_E = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, MDUBusy}, 32'd0);
        chk("rst_mid_hi", HI_out, 32'd0);
        chk("rst_mid_lo", LO_out, 32'd0);
        repeat (DC + 2) @(negedge clk);
        chk("rst_mid_no_commit_hi", HI_out, 32'd0);
        chk("rst_mid_no_commit_lo", LO_out, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            rop = ops[$urandom_range(0, 9)];
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(0, 9));
            run_op(rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
